// File: rtl/display_scan8.sv
// display_scan8: eight-digit multiplexed seven-segment scanner with frame shadow and anti-ghost blanking
module display_scan8 #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] d1,
    input  logic [6:0] d2,
    input  logic [6:0] d3,
    input  logic [6:0] d4,
    input  logic [6:0] d5,
    input  logic [6:0] d6,
    input  logic [6:0] d7,
    input  logic [6:0] d8,
    output logic [7:0] an,
    output logic [7:0] dec_ddp,
    output logic       frame_tick
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK = CW'(BLANK_CYC);

    function automatic logic [6:0] glyph(input logic [4:0] c);
        case (c)
            5'h00:   glyph = 7'h01;
            5'h01:   glyph = 7'h4F;
            5'h02:   glyph = 7'h12;
            5'h03:   glyph = 7'h06;
            5'h04:   glyph = 7'h4C;
            5'h05:   glyph = 7'h18;
            5'h06:   glyph = 7'h24;
            5'h07:   glyph = 7'h30;
            5'h08:   glyph = 7'h70;
            5'h09:   glyph = 7'h41;
            5'h0A:   glyph = 7'h18;
            5'h0B:   glyph = 7'h60;
            5'h0C:   glyph = 7'h31;
            5'h0D:   glyph = 7'h71;
            5'h0E:   glyph = 7'h44;
            5'h0F:   glyph = 7'h21;
            5'h11:   glyph = 7'h7E;
            default: glyph = 7'h7F;
        endcase
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [6:0]    sh_q [8];
    logic [6:0]    din  [8];
    logic [6:0]    cur;
    logic [7:0]    an_q, an_d, ddp_q, ddp_d;
    logic          wrap, load, active;

    assign din        = '{d1, d2, d3, d4, d5, d6, d7, d8};
    assign an         = an_q;
    assign dec_ddp    = ddp_q;
    assign frame_tick = load;

    // Slot timing, frame load strobe and the display word for the next cycle
    always_comb begin
        wrap   = cnt_q == LAST;
        load   = wrap && idx_q == 3'd7;
        cnt_d  = wrap ? '0 : cnt_q + CW'(1);
        idx_d  = wrap ? idx_q + 3'd1 : idx_q;
        cur    = sh_q[idx_q];
        active = (cnt_q >= BLANK) && cur[6];
        an_d   = active ? ~(8'h01 << idx_q) : 8'hFF;
        ddp_d  = active ? {glyph(cur[5:1]), cur[0]} : 8'hFF;
    end

    // Counters, shadow register and registered display outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            idx_q <= '0;
            sh_q  <= '{default: '0};
            an_q  <= 8'hFF;
            ddp_q <= 8'hFF;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            ddp_q <= ddp_d;
            if (load) sh_q <= din;
        end
    end
endmodule

// File: tb/tb_display_scan8.sv
// tb_display_scan8: directed checks of scanning, blanking, shadow loading and reset
module tb_display_scan8;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] d1, d2, d3, d4, d5, d6, d7, d8;
    logic [7:0] an, dec_ddp;
    logic       frame_tick;
    int         total = 0;
    int         bad = 0;
    int         k = 0;

    display_scan8 #(.REFRESH_DIV(8), .BLANK_CYC(2)) dut (
        .clock(clock), .reset(reset),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8),
        .an(an), .dec_ddp(dec_ddp), .frame_tick(frame_tick)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        k++;
    endtask

    task automatic go(input int target);
        while (k < target) step();
    endtask

    task automatic disp(input string tag, input logic [7:0] ea, input logic [7:0] ed);
        check({tag, ".an"}, an, ea);
        check({tag, ".ddp"}, dec_ddp, ed);
    endtask

    initial begin
        d1 = 7'h61; d2 = 7'h61; d3 = 7'h61; d4 = 7'h61;
        d5 = 7'h61; d6 = 7'h61; d7 = 7'h43; d8 = 7'h4B;
        repeat (3) @(negedge clock);
        disp("in_reset", 8'hFF, 8'hFF);
        check("in_reset.ft", 8'(frame_tick), 8'h00);
        reset = 1'b1;
        k = 0;
        for (int i = 0; i < 64; i++) begin
            go(i);
            disp("frame0_blank", 8'hFF, 8'hFF);
            check("frame0.ft", 8'(frame_tick), (i == 63) ? 8'h01 : 8'h00);
        end
        go(64);  disp("f1_first", 8'hFF, 8'hFF);
        go(68);  disp("f1_idx0", 8'hFE, 8'hFF);
        d1 = 7'h63; d2 = 7'h63; d3 = 7'h63; d4 = 7'h63;
        d5 = 7'h63; d6 = 7'h63; d7 = 7'h63; d8 = 7'h63;
        go(112); disp("f1_idx6_c0", 8'hDF, 8'hFF);
        go(113); disp("f1_idx6_c1", 8'hFF, 8'hFF);
        go(114); disp("f1_idx6_c2", 8'hFF, 8'hFF);
        go(115); disp("f1_idx6_on", 8'hBF, 8'h9F);
        go(120); disp("f1_idx7_c0", 8'hBF, 8'h9F);
        go(121); disp("f1_idx7_c1", 8'hFF, 8'hFF);
        go(123); disp("f1_idx7_on", 8'h7F, 8'h31);
        go(127); disp("f1_idx7_c7", 8'h7F, 8'h31);
        check("f1.ft", 8'(frame_tick), 8'h01);
        for (int i = 0; i < 8; i++) begin
            go(128 + 8 * i + 1); disp("f2_blank1", 8'hFF, 8'hFF);
            go(128 + 8 * i + 2); disp("f2_blank2", 8'hFF, 8'hFF);
            go(128 + 8 * i + 3); disp("f2_dash", ~(8'h01 << i), 8'hFD);
            go(128 + 8 * i + 7); disp("f2_dash_end", ~(8'h01 << i), 8'hFD);
            if (i == 0) d1 = 7'h23;
        end
        go(192); disp("f3_c0_prev", 8'h7F, 8'hFD);
        for (int j = 193; j <= 200; j++) begin
            go(j);
            disp("f3_d1_off", 8'hFF, 8'hFF);
        end
        go(211); disp("f3_d3_old", 8'hFB, 8'hFD);
        d3 = 7'h40;
        go(213); disp("f3_d3_hold", 8'hFB, 8'hFD);
        go(254); check("f3.ft_pre", 8'(frame_tick), 8'h00);
        go(255); check("f3.ft", 8'(frame_tick), 8'h01);
        go(260); disp("f4_d1_off", 8'hFF, 8'hFF);
        go(275); disp("f4_d3_new", 8'hFB, 8'h02);
        go(300); disp("f4_idx5", 8'hDF, 8'hFD);
        reset = 1'b0;
        #1;
        disp("async_reset", 8'hFF, 8'hFF);
        check("async_reset.ft", 8'(frame_tick), 8'h00);
        d1 = 7'h63;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        k = 0;
        go(3);  disp("r_blank_idx0", 8'hFF, 8'hFF);
        go(43); disp("r_blank_idx5", 8'hFF, 8'hFF);
        go(62); check("r.ft_pre", 8'(frame_tick), 8'h00);
        go(63); check("r.ft", 8'(frame_tick), 8'h01);
        go(64); disp("r_first", 8'hFF, 8'hFF);
        go(67); disp("r_idx0_on", 8'hFE, 8'hFD);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
